// File: rtl/intf_slot_pkg.sv
// Shared types and slot-numbering helpers for the interface-slot scheduler.
// Declared indices follow SV interface-array order [left:right], either direction.
package intf_slot_pkg;

    localparam int SLOT_DATA_W = 32;
    localparam int REQ_ID_W    = 2;

    typedef logic [SLOT_DATA_W-1:0] slot_data_t;
    typedef logic [REQ_ID_W-1:0]    req_id_t;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    function automatic int slot_phys(input int addr, input int left);
        return (addr >= left) ? (addr - left) : (left - addr);
    endfunction

    function automatic logic slot_legal(input int addr, input int left, input int right);
        int lo;
        int hi;
        lo = (left < right) ? left : right;
        hi = (left < right) ? right : left;
        return (addr >= lo) && (addr <= hi);
    endfunction

    // Declared index of physical slot k.
    function automatic int slot_decl(input int k, input int left, input int right);
        return (left >= right) ? (left - k) : (left + k);
    endfunction

endpackage

// File: rtl/intf_slot_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first request at or above ptr, wrapping.
// The pointer register lives in the parent.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] id,
    output logic                 valid
);

    localparam int ID_W = $clog2(N);

    int idx;

    // Rotating priority search starting at ptr.
    always_comb begin
        gnt   = {N{1'b0}};
        id    = {ID_W{1'b0}};
        valid = 1'b0;
        idx   = 0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(ptr) + i) % N;
            if (!valid && req[idx]) begin
                valid    = 1'b1;
                gnt[idx] = 1'b1;
                id       = ID_W'(idx);
            end else begin
                valid = valid;
            end
        end
    end

endmodule

// File: rtl/intf_slot_sched.sv
// Round-robin scheduler sharing M interface-style slots among N_REQ requesters.
// Runs a power-up init pass over the slots, then serves one access per cycle.
module intf_slot_sched
    import intf_slot_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int SLOT_LEFT  = 4,
    parameter int SLOT_RIGHT = 1,
    parameter int ADDR_W     = 3,
    parameter int DATA_W     = 32,
    parameter int INIT_BASE  = 'h100
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ-1:0]         we,
    input  logic [N_REQ*ADDR_W-1:0]  addr,
    input  logic [N_REQ*DATA_W-1:0]  wdata,
    output logic [N_REQ-1:0]         gnt,
    output logic                     rsp_valid,
    output logic [$clog2(N_REQ)-1:0] rsp_id,
    output logic [DATA_W-1:0]        rsp_rdata,
    output logic                     rsp_err,
    output logic                     busy
);

    localparam int M     = (SLOT_LEFT > SLOT_RIGHT) ? (SLOT_LEFT - SLOT_RIGHT + 1)
                                                    : (SLOT_RIGHT - SLOT_LEFT + 1);
    localparam int ID_W  = $clog2(N_REQ);
    localparam int CNT_W = (M > 1) ? $clog2(M) : 1;

    state_t              state;
    state_t              state_nxt;
    logic [CNT_W-1:0]    init_cnt;
    logic [DATA_W-1:0]   slots [M];
    logic [ID_W-1:0]     ptr;

    logic [N_REQ-1:0]    arb_gnt;
    logic [ID_W-1:0]     arb_id;
    logic                arb_valid;

    logic                grant;
    logic [ADDR_W-1:0]   win_addr;
    logic [DATA_W-1:0]   win_wdata;
    logic                win_we;
    logic                legal;
    int                  phys;
    logic [DATA_W-1:0]   old_data;

    rr_arbiter #(.N(N_REQ)) u_arb (
        .req   (req),
        .ptr   (ptr),
        .gnt   (arb_gnt),
        .id    (arb_id),
        .valid (arb_valid)
    );

    // Grant gating and decode of the winning requester's access.
    always_comb begin
        grant     = (state == ST_RUN) && arb_valid;
        gnt       = (state == ST_RUN) ? arb_gnt : {N_REQ{1'b0}};
        win_addr  = addr[int'(arb_id)*ADDR_W +: ADDR_W];
        win_wdata = wdata[int'(arb_id)*DATA_W +: DATA_W];
        win_we    = we[arb_id];
        legal     = slot_legal(int'(win_addr), SLOT_LEFT, SLOT_RIGHT);
        phys      = slot_phys(int'(win_addr), SLOT_LEFT);
        old_data  = {DATA_W{1'b0}};
        for (int k = 0; k < M; k++) begin
            old_data = (phys == k) ? slots[k] : old_data;
        end
    end

    // Next-state logic: INIT walks every slot once, then RUN forever.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_INIT: begin
                if (init_cnt == CNT_W'(M - 1)) begin
                    state_nxt = ST_RUN;
                end else begin
                    state_nxt = ST_INIT;
                end
            end
            ST_RUN:  state_nxt = ST_RUN;
            default: state_nxt = ST_INIT;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_INIT;
        end else begin
            state <= state_nxt;
        end
    end

    // Init counter, which is also the physical slot being initialised.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            init_cnt <= {CNT_W{1'b0}};
        end else if (state == ST_INIT) begin
            init_cnt <= init_cnt + CNT_W'(1);
        end else begin
            init_cnt <= init_cnt;
        end
    end

    // Slot bank: init values during INIT, granted legal writes during RUN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < M; k++) begin
                slots[k] <= {DATA_W{1'b0}};
            end
        end else begin
            for (int k = 0; k < M; k++) begin
                if ((state == ST_INIT) && (init_cnt == CNT_W'(k))) begin
                    slots[k] <= DATA_W'(INIT_BASE + slot_decl(k, SLOT_LEFT, SLOT_RIGHT));
                end else if (grant && legal && win_we && (phys == k)) begin
                    slots[k] <= win_wdata;
                end else begin
                    slots[k] <= slots[k];
                end
            end
        end
    end

    // Round-robin pointer: one past the last winner.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= {ID_W{1'b0}};
        end else if (grant) begin
            ptr <= (arb_id == ID_W'(N_REQ - 1)) ? {ID_W{1'b0}} : (arb_id + ID_W'(1));
        end else begin
            ptr <= ptr;
        end
    end

    // Response registers; data/id/err hold between strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_id    <= {ID_W{1'b0}};
            rsp_rdata <= {DATA_W{1'b0}};
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= grant;
            if (grant) begin
                rsp_id    <= arb_id;
                rsp_err   <= !legal;
                rsp_rdata <= legal ? old_data : {DATA_W{1'b0}};
            end else begin
                rsp_id    <= rsp_id;
                rsp_err   <= rsp_err;
                rsp_rdata <= rsp_rdata;
            end
        end
    end

    assign busy = (state == ST_INIT);

endmodule

// File: tb/tb_intf_slot_sched.sv
// Scoreboard bench: two instances (descending 4:1, ascending 1:4) share stimulus
// and are checked against a declared-index reference model.
module tb_intf_slot_sched;

    localparam int N  = 4;
    localparam int AW = 3;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [N-1:0]    req;
    logic [N-1:0]    we;
    logic [N*AW-1:0] addr;
    logic [N*DW-1:0] wdata;

    logic [N-1:0]  gnt_a, gnt_b;
    logic          rsp_valid_a, rsp_valid_b;
    logic [1:0]    rsp_id_a, rsp_id_b;
    logic [DW-1:0] rsp_rdata_a, rsp_rdata_b;
    logic          rsp_err_a, rsp_err_b;
    logic          busy_a, busy_b;

    intf_slot_sched u_dut_a (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .gnt(gnt_a), .rsp_valid(rsp_valid_a), .rsp_id(rsp_id_a),
        .rsp_rdata(rsp_rdata_a), .rsp_err(rsp_err_a), .busy(busy_a)
    );

    intf_slot_sched #(.SLOT_LEFT(1), .SLOT_RIGHT(4)) u_dut_b (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .gnt(gnt_b), .rsp_valid(rsp_valid_b), .rsp_id(rsp_id_b),
        .rsp_rdata(rsp_rdata_b), .rsp_err(rsp_err_b), .busy(busy_b)
    );

    typedef struct {
        int          id;
        logic [31:0] rdata;
        logic        err;
        int          due;
    } rsp_t;

    rsp_t        exp_q[$];
    logic [31:0] mem [int];
    int          ptr;
    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 1; i <= 4; i++) mem[i] = 32'h100 + 32'(i);
        ptr = 0;
        exp_q.delete();
    endtask

    // Monitor: pops the scoreboard whenever a response is presented.
    always @(negedge clk) begin
        if (!rst) begin
            rsp_t e;
            cyc++;
            chk("rsp_valid_b_vs_a", 32'(rsp_valid_b), 32'(rsp_valid_a));
            if (rsp_valid_a) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_timing", 32'(cyc), 32'(e.due));
                    chk("rsp_id_a", 32'(rsp_id_a), 32'(e.id));
                    chk("rsp_rdata_a", rsp_rdata_a, e.rdata);
                    chk("rsp_err_a", 32'(rsp_err_a), 32'(e.err));
                    chk("rsp_id_b", 32'(rsp_id_b), 32'(e.id));
                    chk("rsp_rdata_b", rsp_rdata_b, e.rdata);
                    chk("rsp_err_b", 32'(rsp_err_b), 32'(e.err));
                end
            end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
                e = exp_q.pop_front();
                chk("missing_rsp", 32'd0, 32'd1);
            end
        end
    end

    // One cycle, entered at a negedge: drive, check grant, update model, advance.
    task automatic cycle(input logic [N-1:0] r, input logic [N-1:0] w,
                         input logic [N*AW-1:0] a, input logic [N*DW-1:0] d,
                         output int win);
        logic [N-1:0] exp_gnt;
        rsp_t         e;
        int           av;
        req = r; we = w; addr = a; wdata = d;
        #1;
        win = -1;
        for (int k = 0; k < N; k++) begin
            if (win < 0 && r[(ptr + k) % N]) win = (ptr + k) % N;
        end
        exp_gnt = (win >= 0) ? N'(1 << win) : '0;
        chk("gnt_a", 32'(gnt_a), 32'(exp_gnt));
        chk("gnt_b", 32'(gnt_b), 32'(exp_gnt));
        if (win >= 0) begin
            av      = int'(a[win*AW +: AW]);
            e.id    = win;
            e.err   = !(av >= 1 && av <= 4);
            e.rdata = e.err ? 32'h0 : mem[av];
            e.due   = cyc + 1;
            exp_q.push_back(e);
            if (!e.err && w[win]) mem[av] = d[win*DW +: DW];
            ptr = (win + 1) % N;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic one(input int id, input logic w, input int adr, input logic [31:0] dat,
                       output int win);
        logic [N-1:0]    r;
        logic [N*AW-1:0] a;
        logic [N*DW-1:0] d;
        r = '0; a = '0; d = '0;
        r[id] = 1'b1;
        a[id*AW +: AW] = AW'(adr);
        d[id*DW +: DW] = dat;
        cycle(r, w ? r : '0, a, d, win);
    endtask

    task automatic do_reset(input logic [N-1:0] hold);
        rst = 1'b1; req = hold; we = '0;
        @(negedge clk);
        @(negedge clk);
        model_reset();
        chk("rst_busy_a", 32'(busy_a), 32'd1);
        chk("rst_gnt_a", 32'(gnt_a), 32'd0);
        chk("rst_rsp_valid_a", 32'(rsp_valid_a), 32'd0);
        chk("rst_rsp_rdata_a", rsp_rdata_a, 32'd0);
        chk("rst_busy_b", 32'(busy_b), 32'd1);
        rst = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            chk("init_busy_a", 32'(busy_a), 32'(c < 4));
            chk("init_busy_b", 32'(busy_b), 32'(c < 4));
            if (c < 4) chk("init_gnt_held", 32'(gnt_a), 32'd0);
        end
        req = '0;
    endtask

    initial begin
        int win;
        logic [N-1:0]    pend;
        logic [N-1:0]    pw;
        logic [N*AW-1:0] pa;
        logic [N*DW-1:0] pd;
        req = '0; we = '0; addr = '0; wdata = '0;

        // Reset release, then read every declared index.
        do_reset(4'b0101);
        for (int i = 1; i <= 4; i++) begin
            one(0, 1'b0, i, 32'h0, win);
            chk("init_value", rsp_rdata_a, 32'h100 + 32'(i));
        end

        // Out-of-range addresses, including writes, leave the slots alone.
        one(2, 1'b1, 0, 32'hDEAD, win);
        chk("err_addr0", 32'(rsp_err_a), 32'd1);
        chk("err_rdata0", rsp_rdata_b, 32'd0);
        one(2, 1'b1, 5, 32'hBEEF, win);
        chk("err_addr5", 32'(rsp_err_b), 32'd1);
        for (int i = 1; i <= 4; i++) one(3, 1'b0, i, 32'h0, win);

        // All requesters held for 8 cycles.
        do_reset('0);
        for (int i = 0; i < 8; i++) begin
            cycle(4'hF, 4'h0, {3'd1, 3'd2, 3'd3, 3'd4}, '0, win);
            chk("rr_order", 32'(win), 32'(i % 4));
        end

        // Write then read of the same slot from different requesters.
        do_reset('0);
        one(0, 1'b1, 2, 32'hABC, win);
        chk("rbw_old", rsp_rdata_a, 32'h102);
        one(1, 1'b0, 2, 32'h0, win);
        chk("rbw_new", rsp_rdata_a, 32'hABC);

        // Reset while a response is showing.
        chk("pre_rst_valid", 32'(rsp_valid_a), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_rsp_valid", 32'(rsp_valid_a), 32'd0);
        chk("async_busy", 32'(busy_a), 32'd1);
        exp_q.delete();
        do_reset('0);
        one(1, 1'b0, 2, 32'h0, win);
        chk("post_rst_reinit", rsp_rdata_a, 32'h102);

        // Lone requester 3 with pointer at 1 wraps the pointer to 0.
        do_reset('0);
        one(0, 1'b0, 1, 32'h0, win);
        one(3, 1'b0, 1, 32'h0, win);
        chk("lone_req3", 32'(win), 32'd3);
        cycle(4'b1001, 4'b0000, '0, '0, win);
        chk("ptr_wrapped", 32'(win), 32'd0);

        // Randomised traffic; a requester holds its access until granted.
        pend = '0; pw = '0; pa = '0; pd = '0;
        for (int t = 0; t < 600; t++) begin
            for (int k = 0; k < N; k++) begin
                if (!pend[k] && $urandom_range(0, 1) == 1) begin
                    pend[k] = 1'b1;
                    pw[k] = 1'($urandom_range(0, 1));
                    pa[k*AW +: AW] = AW'($urandom_range(0, 7) < 6 ? $urandom_range(1, 4)
                                                                  : $urandom_range(0, 7));
                    pd[k*DW +: DW] = $urandom;
                end
            end
            cycle(pend, pw, pa, pd, win);
            if (win >= 0) pend[win] = 1'b0;
        end
        req = '0;
        @(negedge clk);
        @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
